// File: rtl/board_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// othello_pkg
// Shared definitions for the Othello board RAM arbiter slice.
//   - cell encodings stored in the 2-bit board RAM
//   - board geometry (100 cells on a 10x10 grid, border included)
//   - arbiter phase encoding (INIT while the board is being filled, RUN while
//     the game engine and display share the RAM)
// -----------------------------------------------------------------------------
package othello_pkg;

    localparam int BOARD_ADDR_W = 8;
    localparam int CELL_W       = 2;
    localparam int BOARD_CELLS  = 100;
    localparam int STARVE_LIMIT = 4;

    localparam logic [CELL_W-1:0] CELL_EMPTY  = 2'b00;
    localparam logic [CELL_W-1:0] CELL_BLACK  = 2'b01;
    localparam logic [CELL_W-1:0] CELL_WHITE  = 2'b10;
    localparam logic [CELL_W-1:0] CELL_BORDER = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/board_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// board_mem_arbiter_if
// Bus between the arbiter and the single-port board RAM.
//   mem_addr  RAM address            (arbiter -> RAM)
//   mem_data  RAM write data         (arbiter -> RAM)
//   mem_wren  RAM write enable       (arbiter -> RAM)
//   mem_q     RAM read data, valid one cycle after the address (RAM -> arbiter)
// modport master: the arbiter side; modport slave: the RAM side.
// -----------------------------------------------------------------------------
interface board_mem_arbiter_if #(
    parameter int ADDR_W = othello_pkg::BOARD_ADDR_W,
    parameter int DATA_W = othello_pkg::CELL_W
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_wren,
        input  mem_q
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_wren,
        output mem_q
    );

endinterface

// File: rtl/board_mem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
// Saturating counter of consecutive display denials.
//   clock  in   system clock
//   reset  in   synchronous, active-low
//   inc    in   count one more denial (ignored once saturated)
//   clr    in   clear to zero; wins over inc
//   sat    out  counter has reached MAX
// -----------------------------------------------------------------------------
module starve_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != W'(MAX))) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign sat = (cnt_reg == W'(MAX));

endmodule

// File: rtl/board_mem_arbiter.sv
// -----------------------------------------------------------------------------
// board_mem_arbiter
// Shares the single-port 10x10 Othello board RAM between the board
// initializer, the game engine (read/write) and the VGA display reader.
//   clock, reset          system clock; synchronous active-low reset
//   restart               pulse in RUN: go back to INIT for a new game
//   init_done             initializer finished; INIT -> RUN
//   init_req/addr/data    initializer write port, init_gnt = served this cycle
//   eng_req/wren/addr/wdata, eng_gnt, eng_rvalid, eng_rdata   engine port
//   disp_req/addr, disp_gnt, disp_rvalid, disp_rdata          display port
//   mem                   RAM bus (board_mem_arbiter_if.master)
//   range_err             sticky flag: an out-of-range access was granted
// Grants are combinational in the request cycle; read data returns one cycle
// later as a single-cycle rvalid pulse. While reset is low every output is
// forced to zero, which also drops a read return that is in flight.
// -----------------------------------------------------------------------------
module board_mem_arbiter
    import othello_pkg::*;
#(
    parameter int ADDR_W     = BOARD_ADDR_W,
    parameter int DATA_W     = CELL_W,
    parameter int NUM_CELLS  = BOARD_CELLS,
    parameter int STARVE_MAX = STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic              init_done,

    input  logic              init_req,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              init_gnt,

    input  logic              eng_req,
    input  logic              eng_wren,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,

    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,

    board_mem_arbiter_if.master mem,

    output logic              range_err
);

    localparam int NUM_RD = 2;  // read ports: 0 = engine, 1 = display

    arb_state_t        state_reg;
    logic              run_st;

    logic              init_gnt_c;
    logic              eng_gnt_c;
    logic              disp_gnt_c;
    logic              any_gnt;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_wr;
    logic              sel_oor;

    logic              starve_inc;
    logic              starve_clr;
    logic              starve_sat;

    logic              rd_oor_reg;
    logic              range_err_reg;
    logic [DATA_W-1:0] ret_data;

    logic [NUM_RD-1:0]             rd_gnt;
    logic [NUM_RD-1:0]             rvalid_vec;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata_vec;

    assign run_st = (state_reg == ST_RUN);

    // -------------------------------------------------------------------------
    // Phase FSM. restart is only meaningful in RUN; in INIT it is ignored.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_INIT;
        end else begin
            case (state_reg)
                ST_INIT: if (init_done) state_reg <= ST_RUN;
                ST_RUN:  if (restart)   state_reg <= ST_INIT;
                default:                state_reg <= ST_INIT;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Grant selection. Display normally loses to the engine, but once it has
    // been denied STARVE_MAX cycles in a row it takes the next cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        init_gnt_c = 1'b0;
        eng_gnt_c  = 1'b0;
        disp_gnt_c = 1'b0;
        if (reset) begin
            if (!run_st) begin
                init_gnt_c = init_req;
            end else if (disp_req && (starve_sat || !eng_req)) begin
                disp_gnt_c = 1'b1;
            end else if (eng_req) begin
                eng_gnt_c = 1'b1;
            end
        end
    end

    assign any_gnt = init_gnt_c | eng_gnt_c | disp_gnt_c;

    // RAM bus mux; an idle bus drives zeros.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        if (init_gnt_c) begin
            sel_addr = init_addr;
            sel_data = init_data;
            sel_wr   = 1'b1;
        end else if (eng_gnt_c) begin
            sel_addr = eng_addr;
            sel_data = eng_wdata;
            sel_wr   = eng_wren;
        end else if (disp_gnt_c) begin
            sel_addr = disp_addr;
        end
    end

    // Out-of-range accesses are still granted (the requester must not hang)
    // but never reach the RAM as writes, and reads return a border cell.
    assign sel_oor = any_gnt && (sel_addr >= ADDR_W'(NUM_CELLS));

    assign mem.mem_addr = sel_addr;
    assign mem.mem_data = sel_data;
    assign mem.mem_wren = sel_wr & ~sel_oor;

    assign init_gnt = init_gnt_c;
    assign eng_gnt  = eng_gnt_c;
    assign disp_gnt = disp_gnt_c;

    // -------------------------------------------------------------------------
    // Display starvation tracking. A restart clears it so a new game starts
    // from plain engine priority.
    // -------------------------------------------------------------------------
    assign starve_inc = run_st & disp_req & ~disp_gnt_c;
    assign starve_clr = disp_gnt_c | ~disp_req | (run_st & restart);

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

    // -------------------------------------------------------------------------
    // Read return pipeline. Only one read is granted per cycle, so a single
    // out-of-range tag serves both ports.
    // -------------------------------------------------------------------------
    assign rd_gnt = {disp_gnt_c, eng_gnt_c & ~eng_wren};

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_oor_reg    <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            rd_oor_reg <= sel_oor & (|rd_gnt);
            if (sel_oor) begin
                range_err_reg <= 1'b1;
            end
        end
    end

    assign ret_data = rd_oor_reg ? DATA_W'(CELL_BORDER) : mem.mem_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic              tag_reg;
            logic [DATA_W-1:0] hold_reg;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    tag_reg  <= 1'b0;
                    hold_reg <= '0;
                end else begin
                    tag_reg <= rd_gnt[gi];
                    if (tag_reg) begin
                        hold_reg <= ret_data;
                    end
                end
            end

            // Data is presented straight from the RAM in the return cycle and
            // held afterwards so rdata keeps its last value between reads.
            assign rvalid_vec[gi] = tag_reg & reset;
            assign rdata_vec[gi]  = !reset ? '0 : (tag_reg ? ret_data : hold_reg);
        end
    endgenerate

    assign eng_rvalid  = rvalid_vec[0];
    assign eng_rdata   = rdata_vec[0];
    assign disp_rvalid = rvalid_vec[1];
    assign disp_rdata  = rdata_vec[1];

    assign range_err = range_err_reg & reset;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_board_mem_arbiter
// Directed bench for board_mem_arbiter with a behavioural board RAM.
// Stimulus pushes expected RAM writes and read returns into queues; a monitor
// on the falling edge pops and compares whenever the DUT writes the RAM or
// pulses an rvalid. Grant and flag expectations are checked inline.
// -----------------------------------------------------------------------------
module tb_board_mem_arbiter;
    import othello_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       restart;
    logic       init_done;
    logic       init_req;
    logic [7:0] init_addr;
    logic [1:0] init_data;
    logic       init_gnt;
    logic       eng_req;
    logic       eng_wren;
    logic [7:0] eng_addr;
    logic [1:0] eng_wdata;
    logic       eng_gnt;
    logic       eng_rvalid;
    logic [1:0] eng_rdata;
    logic       disp_req;
    logic [7:0] disp_addr;
    logic       disp_gnt;
    logic       disp_rvalid;
    logic [1:0] disp_rdata;
    logic       range_err;

    int checks = 0;
    int errors = 0;

    logic [9:0] wr_q[$];
    logic [1:0] eng_q[$];
    logic [1:0] disp_q[$];

    logic [1:0] ram [256];

    always #5 clock = ~clock;

    board_mem_arbiter_if bus ();

    board_mem_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .restart     (restart),
        .init_done   (init_done),
        .init_req    (init_req),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .init_gnt    (init_gnt),
        .eng_req     (eng_req),
        .eng_wren    (eng_wren),
        .eng_addr    (eng_addr),
        .eng_wdata   (eng_wdata),
        .eng_gnt     (eng_gnt),
        .eng_rvalid  (eng_rvalid),
        .eng_rdata   (eng_rdata),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .mem         (bus.master),
        .range_err   (range_err)
    );

    // Board RAM: 100 valid cells, 1-cycle synchronous read.
    always @(posedge clock) begin
        if (bus.mem_wren && (bus.mem_addr < 8'd100)) ram[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= ram[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write and every read return must match the queue head.
    always @(negedge clock) begin
        if (bus.mem_wren === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_wr_unexpected: got addr %0d data %b required no write", bus.mem_addr, bus.mem_data);
            end else begin
                $display("tx write addr %0d data %b", bus.mem_addr, bus.mem_data);
                check("mem_wr", {bus.mem_addr, bus.mem_data}, wr_q.pop_front());
            end
        end
        if (eng_rvalid === 1'b1) begin
            if (eng_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL eng_rvalid_unexpected: got rdata %b required no rvalid", eng_rdata);
            end else begin
                $display("tx eng read data %b", eng_rdata);
                check("eng_rdata", eng_rdata, eng_q.pop_front());
            end
        end
        if (disp_rvalid === 1'b1) begin
            if (disp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL disp_rvalid_unexpected: got rdata %b required no rvalid", disp_rdata);
            end else begin
                $display("tx disp read data %b", disp_rdata);
                check("disp_rdata", disp_rdata, disp_q.pop_front());
            end
        end
    end

    function automatic logic [1:0] board_cell(input int a);
        int r;
        int c;
        r = a / 10;
        c = a % 10;
        return (r == 0 || r == 9 || c == 0 || c == 9) ? 2'b11 : 2'b00;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_gnt(input string tag, input logic ei, input logic ee, input logic ed);
        @(negedge clock);
        check({tag, "_init_gnt"}, init_gnt, ei);
        check({tag, "_eng_gnt"}, eng_gnt, ee);
        check({tag, "_disp_gnt"}, disp_gnt, ed);
        step();
    endtask

    initial begin
        bit d;
        reset = 1'b0; restart = 1'b0; init_done = 1'b0;
        init_req = 1'b1; init_addr = 8'd3; init_data = 2'b11;
        eng_req = 1'b1; eng_wren = 1'b1; eng_addr = 8'd4; eng_wdata = 2'b01;
        disp_req = 1'b1; disp_addr = 8'd5;

        // ---- reset: everything quiet despite active requests ----
        step(); step();
        @(negedge clock);
        check("rst_init_gnt", init_gnt, 0);
        check("rst_eng_gnt", eng_gnt, 0);
        check("rst_disp_gnt", disp_gnt, 0);
        check("rst_mem_wren", bus.mem_wren, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_data", bus.mem_data, 0);
        check("rst_rvalid", {eng_rvalid, disp_rvalid}, 0);
        check("rst_rdata", {eng_rdata, disp_rdata}, 0);
        check("rst_range_err", range_err, 0);
        step();

        // ---- 1: initializer fills the board, engine locked out ----
        reset = 1'b1; eng_wren = 1'b0; disp_req = 1'b0;
        for (int a = 0; a < 100; a++) begin
            init_req = 1'b1; init_addr = 8'(a); init_data = board_cell(a);
            wr_q.push_back({8'(a), board_cell(a)});
            expect_gnt("t1_fill", 1, 0, 0);
        end
        init_req = 1'b0; init_done = 1'b1; eng_req = 1'b0;
        expect_gnt("t1_done", 0, 0, 0);
        init_done = 1'b0; init_req = 1'b1; init_addr = 8'd50; init_data = 2'b01;
        @(negedge clock);
        check("t1_run_init_ignored", init_gnt, 0);
        check("t1_run_no_wren", bus.mem_wren, 0);
        step();
        init_req = 1'b0;

        // ---- 2: engine write then read of cell 44 ----
        eng_req = 1'b1; eng_wren = 1'b1; eng_addr = 8'd44; eng_wdata = 2'b01;
        wr_q.push_back({8'd44, 2'b01});
        expect_gnt("t2_wr", 0, 1, 0);
        eng_wren = 1'b0;
        eng_q.push_back(2'b01);
        expect_gnt("t2_rd", 0, 1, 0);
        eng_req = 1'b0;
        @(negedge clock);
        check("t2_eng_rvalid", eng_rvalid, 1);
        check("t2_disp_rvalid", disp_rvalid, 0);
        step();

        // ---- 3: both held; display promoted every 5th cycle ----
        eng_req = 1'b1; eng_wren = 1'b0; eng_addr = 8'd44;
        disp_req = 1'b1; disp_addr = 8'd0;
        for (int i = 0; i < 10; i++) begin
            d = (i % 5 == 4);
            if (d) disp_q.push_back(2'b11);
            else   eng_q.push_back(2'b01);
            expect_gnt("t3_share", 0, !d, d);
        end
        eng_req = 1'b0; disp_req = 1'b0;
        expect_gnt("t3_idle", 0, 0, 0);

        // ---- 4: range guard at and beyond the last cell ----
        @(negedge clock);
        check("t4_range_err_clear", range_err, 0);
        eng_req = 1'b1; eng_wren = 1'b1; eng_addr = 8'd99; eng_wdata = 2'b01;
        wr_q.push_back({8'd99, 2'b01});
        step();
        eng_addr = 8'd120;
        @(negedge clock);
        check("t4_oor_eng_gnt", eng_gnt, 1);
        check("t4_oor_mem_wren", bus.mem_wren, 0);
        check("t4_range_err_not_yet", range_err, 0);
        step();
        eng_wren = 1'b0; eng_addr = 8'd99;
        eng_q.push_back(2'b01);
        @(negedge clock);
        check("t4_range_err_set", range_err, 1);
        check("t4_rd99_gnt", eng_gnt, 1);
        step();
        eng_req = 1'b0; disp_req = 1'b1; disp_addr = 8'd150;
        disp_q.push_back(2'b11);
        expect_gnt("t4_disp_oor", 0, 0, 1);
        disp_req = 1'b0; eng_req = 1'b1; eng_addr = 8'd100;
        eng_q.push_back(2'b11);
        expect_gnt("t4_eng_oor", 0, 1, 0);
        eng_addr = 8'd44;
        eng_q.push_back(2'b01);
        expect_gnt("t4_eng_back", 0, 1, 0);
        eng_req = 1'b0;
        @(negedge clock);
        check("t4_range_err_sticky", range_err, 1);
        step();

        // ---- 5: restart clears starvation and returns to INIT ----
        eng_req = 1'b1; eng_addr = 8'd44; disp_req = 1'b1; disp_addr = 8'd0;
        eng_q.push_back(2'b01); expect_gnt("t5_pre", 0, 1, 0);
        eng_q.push_back(2'b01); expect_gnt("t5_pre", 0, 1, 0);
        restart = 1'b1;
        eng_q.push_back(2'b01); expect_gnt("t5_restart", 0, 1, 0);
        restart = 1'b0; init_req = 1'b1; init_addr = 8'd12; init_data = 2'b10;
        wr_q.push_back({8'd12, 2'b10});
        expect_gnt("t5_init", 1, 0, 0);
        init_req = 1'b0; init_done = 1'b1;
        expect_gnt("t5_done", 0, 0, 0);
        init_done = 1'b0; eng_addr = 8'd12;
        for (int i = 0; i < 5; i++) begin
            d = (i == 4);
            if (d) disp_q.push_back(2'b11);
            else   eng_q.push_back(2'b10);
            expect_gnt("t5_share", 0, !d, d);
        end
        eng_req = 1'b0; disp_req = 1'b0;
        expect_gnt("t5_idle", 0, 0, 0);

        // ---- 6: reset right after a display read grant ----
        disp_req = 1'b1; disp_addr = 8'd12;
        expect_gnt("t6_grant", 0, 0, 1);
        reset = 1'b0; disp_req = 1'b0;
        init_req = 1'b1; init_addr = 8'd7; init_data = 2'b01; eng_req = 1'b1;
        @(negedge clock);
        check("t6_disp_rvalid", disp_rvalid, 0);
        check("t6_eng_rvalid", eng_rvalid, 0);
        check("t6_gnts", {init_gnt, eng_gnt, disp_gnt}, 0);
        check("t6_rdata", {eng_rdata, disp_rdata}, 0);
        check("t6_mem_bus", {bus.mem_wren, bus.mem_addr, bus.mem_data}, 0);
        check("t6_range_err", range_err, 0);
        step(); step();
        reset = 1'b1; eng_req = 1'b0; init_data = 2'b11;
        wr_q.push_back({8'd7, 2'b11});
        @(negedge clock);
        check("t6_post_init_gnt", init_gnt, 1);
        check("t6_post_range_err", range_err, 0);
        step();
        init_req = 1'b0;
        step(); step();

        check("end_wr_q_empty", wr_q.size(), 0);
        check("end_eng_q_empty", eng_q.size(), 0);
        check("end_disp_q_empty", disp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
